// File: rtl/dma_pkg.sv
// Shared definitions for the DMA read request issuer slice.
//  - PCIe TLP format/type codes for a 3DW memory read request (MRd32)
//  - header double-word offsets inside the 96-bit single-beat header
//  - issuer FSM state encoding
//  - build_mrd32_hdr(): assembles {DW0,DW1,DW2} for one read chunk
package dma_pkg;

    // Memory read, 32-bit address, no payload.
    localparam logic [2:0] TLP_FMT_3DW_NODATA = 3'b000;
    localparam logic [4:0] TLP_TYPE_MRD       = 5'b00000;

    // Bit offsets of each header double word within m_hdr.
    localparam int HDR_DW0_LSB = 64;
    localparam int HDR_DW1_LSB = 32;
    localparam int HDR_DW2_LSB = 0;

    localparam logic [3:0] BE_FULL = 4'hF;
    localparam logic [3:0] BE_NONE = 4'h0;

    // Issuer FSM states.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Builds the MRd32 header. The length field is 10 bits wide, so a
    // 4096-byte request naturally encodes as 0 (which PCIe reads as 1024 DW).
    // A single-DW request must carry lastBE = 0.
    function automatic logic [95:0] build_mrd32_hdr(
        input logic [15:0] requester_id,
        input logic [7:0]  tag,
        input logic [31:0] addr,
        input logic [31:0] size
    );
        logic [9:0]  len;
        logic [3:0]  last_be;
        logic [31:0] dw0;
        logic [31:0] dw1;
        logic [31:0] dw2;
        len     = size[11:2];
        last_be = (len == 10'd1) ? BE_NONE : BE_FULL;
        // fmt, type, R, TC, R, TD, EP, attr, AT, length
        dw0 = {TLP_FMT_3DW_NODATA, TLP_TYPE_MRD, 1'b0, 3'b000, 4'b0000,
               1'b0, 1'b0, 2'b00, 2'b00, len};
        dw1 = {requester_id, tag, last_be, BE_FULL};
        dw2 = {addr[31:2], 2'b00};
        return {dw0, dw1, dw2};
    endfunction

endpackage

// File: rtl/dma_tag_pool.sv
// Read-tag pool for the DMA read request issuer.
// Tracks NUM_TAGS = 2**TAG_W tags in a bitmap (1 = allocated).
//  i_clk, i_rst    clock, asynchronous active-high reset (all tags freed)
//  alloc           take the lowest-numbered free tag this cycle (ignored if none)
//  avail           at least one tag is free
//  alloc_tag       lowest-numbered free tag (valid when avail)
//  free_valid      release free_tag this cycle
//  free_tag        tag to release; values >= NUM_TAGS are rejected
//  outstanding     number of allocated tags
//  err_spurious    one-cycle pulse after a free of an unallocated/out-of-range tag
module dma_tag_pool
    import dma_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       alloc,
    output logic       avail,
    output logic [7:0] alloc_tag,
    input  logic       free_valid,
    input  logic [7:0] free_tag,
    output logic [8:0] outstanding,
    output logic       err_spurious
);

    localparam int NUM_TAGS = 1 << TAG_W;

    logic [NUM_TAGS-1:0] bitmap_reg;
    logic [NUM_TAGS-1:0] bitmap_next;
    logic [NUM_TAGS-1:0] alloc_onehot;
    logic [NUM_TAGS-1:0] free_onehot;
    logic [8:0]          count_reg;
    logic [8:0]          count_next;
    logic                err_spurious_reg;
    logic                free_in_range;
    logic                free_hit;
    logic                alloc_fire;

    // Lowest-numbered free tag: scan downwards so the last hit wins.
    always_comb begin
        avail     = 1'b0;
        alloc_tag = 8'd0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!bitmap_reg[i]) begin
                avail     = 1'b1;
                alloc_tag = 8'(i);
            end
        end
    end

    assign alloc_fire    = alloc && avail;
    assign free_in_range = ((free_tag >> TAG_W) == 8'd0);
    // A free only counts against a currently allocated tag. Because alloc
    // always picks a tag that is free in bitmap_reg, the two masks never
    // overlap, and a tag freed this cycle is only visible as free next cycle.
    assign free_hit      = free_valid && free_in_range && bitmap_reg[free_tag[TAG_W-1:0]];

    generate
        for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_tag
            assign alloc_onehot[gi] = alloc_fire && (alloc_tag == 8'(gi));
            assign free_onehot[gi]  = free_hit && (free_tag[TAG_W-1:0] == TAG_W'(gi));
        end
    endgenerate

    assign bitmap_next = (bitmap_reg | alloc_onehot) & ~free_onehot;
    assign count_next  = count_reg + {8'd0, alloc_fire} - {8'd0, free_hit};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bitmap_reg       <= '0;
            count_reg        <= 9'd0;
            err_spurious_reg <= 1'b0;
        end else begin
            bitmap_reg       <= bitmap_next;
            count_reg        <= count_next;
            err_spurious_reg <= free_valid && !free_hit;
        end
    end

    assign outstanding  = count_reg;
    assign err_spurious = err_spurious_reg;

endmodule

// File: rtl/dma_read_request_issuer.sv
// DMA read request issuer: consumes split chunks one at a time.
//  Read chunk  -> one MRd32 header (96-bit single beat) on m_hdr/m_hdr_valid/m_hdr_ready,
//                 carrying a tag from the internal pool.
//  Write chunk -> offered to the write engine on wr_req_valid/wr_req_ready.
//  Illegal chunk (size 0, > MAX_BYTES, not DW multiple, unaligned addr) -> err_size, skipped.
//  Every chunk ends with a one-cycle dma_done so the splitter advances.
// Ports:
//  i_clk, i_rst                clock, asynchronous active-high reset
//  cfg_requester_id            requester ID for DW1
//  dma_pending/address/size/dir_write   chunk from splitter (level)
//  dma_done                    one-cycle chunk-consumed pulse
//  m_hdr, m_hdr_valid, m_hdr_ready      header stream
//  wr_req_valid, wr_req_ready  write chunk handshake
//  cpl_free_valid, cpl_free_tag         tag release from completion reassembler
//  outstanding                 allocated tag count
//  err_size, err_spurious      one-cycle error pulses
module dma_read_request_issuer
    import dma_pkg::*;
#(
    parameter int TAG_W     = 5,
    parameter int MAX_BYTES = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] cfg_requester_id,
    input  logic        dma_pending,
    input  logic [31:0] dma_address_host,
    input  logic [31:0] dma_size,
    input  logic        dma_dir_write,
    output logic        dma_done,
    output logic [95:0] m_hdr,
    output logic        m_hdr_valid,
    input  logic        m_hdr_ready,
    output logic        wr_req_valid,
    input  logic        wr_req_ready,
    input  logic        cpl_free_valid,
    input  logic [7:0]  cpl_free_tag,
    output logic [8:0]  outstanding,
    output logic        err_size,
    output logic        err_spurious
);

    logic [2:0]  state_reg;
    logic [2:0]  state_next;
    logic [31:0] addr_reg;
    logic [31:0] size_reg;
    logic        dir_reg;
    logic [95:0] hdr_reg;
    logic        m_hdr_valid_reg;
    logic        wr_req_valid_reg;
    logic        dma_done_reg;
    logic        err_size_reg;

    logic        illegal;
    logic        pool_avail;
    logic [7:0]  pool_tag;
    logic        alloc;

    assign illegal = (size_reg == 32'd0)
                  || (size_reg > 32'(MAX_BYTES))
                  || (size_reg[1:0] != 2'b00)
                  || (addr_reg[1:0] != 2'b00);

    // The tag is taken on the CHECK->ISSUE edge so the header can be
    // registered with it and stay stable for the whole ISSUE state.
    assign alloc = (state_reg == ST_CHECK) && !illegal && !dir_reg && pool_avail;

    dma_tag_pool #(
        .TAG_W(TAG_W)
    ) u_tag_pool (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .alloc       (alloc),
        .avail       (pool_avail),
        .alloc_tag   (pool_tag),
        .free_valid  (cpl_free_valid),
        .free_tag    (cpl_free_tag),
        .outstanding (outstanding),
        .err_spurious(err_spurious)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (dma_pending) state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (illegal)         state_next = ST_DONE;
                else if (dir_reg)    state_next = ST_WRITE;
                else if (pool_avail) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (m_hdr_valid_reg && m_hdr_ready) state_next = ST_DONE;
            end
            ST_WRITE: begin
                if (wr_req_valid_reg && wr_req_ready) state_next = ST_DONE;
            end
            // DONE always returns to IDLE, so dma_pending is never sampled
            // in the cycle the splitter is updating its chunk registers.
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg        <= ST_IDLE;
            addr_reg         <= 32'd0;
            size_reg         <= 32'd0;
            dir_reg          <= 1'b0;
            hdr_reg          <= 96'd0;
            m_hdr_valid_reg  <= 1'b0;
            wr_req_valid_reg <= 1'b0;
            dma_done_reg     <= 1'b0;
            err_size_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == ST_IDLE) && dma_pending) begin
                addr_reg <= dma_address_host;
                size_reg <= dma_size;
                dir_reg  <= dma_dir_write;
            end
            if (alloc) begin
                hdr_reg <= build_mrd32_hdr(cfg_requester_id, pool_tag, addr_reg, size_reg);
            end
            // Handshake/pulse outputs are registered off the next state so
            // they line up exactly with state occupancy.
            m_hdr_valid_reg  <= (state_next == ST_ISSUE);
            wr_req_valid_reg <= (state_next == ST_WRITE);
            dma_done_reg     <= (state_next == ST_DONE);
            err_size_reg     <= (state_reg == ST_CHECK) && illegal;
        end
    end

    assign m_hdr        = hdr_reg;
    assign m_hdr_valid  = m_hdr_valid_reg;
    assign wr_req_valid = wr_req_valid_reg;
    assign dma_done     = dma_done_reg;
    assign err_size     = err_size_reg;

endmodule

// File: tb/tb_dma_read_request_issuer.sv
// Self-checking bench for dma_read_request_issuer: directed scenarios followed
// by randomized chunks/frees, checked against a tag-pool and header model.
module tb_dma_read_request_issuer;

    localparam int NUM_TAGS = 32;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [15:0] cfg_requester_id;
    logic        dma_pending;
    logic [31:0] dma_address_host;
    logic [31:0] dma_size;
    logic        dma_dir_write;
    logic        dma_done;
    logic [95:0] m_hdr;
    logic        m_hdr_valid;
    logic        m_hdr_ready;
    logic        wr_req_valid;
    logic        wr_req_ready;
    logic        cpl_free_valid;
    logic [7:0]  cpl_free_tag;
    logic [8:0]  outstanding;
    logic        err_size;
    logic        err_spurious;

    always #5 i_clk = ~i_clk;

    dma_read_request_issuer dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .cfg_requester_id(cfg_requester_id),
        .dma_pending     (dma_pending),
        .dma_address_host(dma_address_host),
        .dma_size        (dma_size),
        .dma_dir_write   (dma_dir_write),
        .dma_done        (dma_done),
        .m_hdr           (m_hdr),
        .m_hdr_valid     (m_hdr_valid),
        .m_hdr_ready     (m_hdr_ready),
        .wr_req_valid    (wr_req_valid),
        .wr_req_ready    (wr_req_ready),
        .cpl_free_valid  (cpl_free_valid),
        .cpl_free_tag    (cpl_free_tag),
        .outstanding     (outstanding),
        .err_size        (err_size),
        .err_spurious    (err_spurious)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          used [NUM_TAGS];
    logic [31:0] cur_addr;
    logic [31:0] cur_size;
    logic        cur_dir;

    task automatic chk(input string name, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < NUM_TAGS; i++) if (used[i]) n++;
        return n;
    endfunction

    function automatic int model_lowest();
        for (int i = 0; i < NUM_TAGS; i++) if (!used[i]) return i;
        return -1;
    endfunction

    // Header computed from the field definitions with plain arithmetic.
    function automatic logic [95:0] exp_hdr(input logic [31:0] a, input logic [31:0] s,
                                            input logic [15:0] id, input int tag);
        logic [31:0] len, lbe, dw0, dw1, dw2;
        len = (s / 4) % 1024;
        lbe = (len == 1) ? 0 : 15;
        dw0 = len;
        dw1 = {16'h0, id} * 65536 + tag * 256 + lbe * 16 + 15;
        dw2 = a - (a % 4);
        return {dw0, dw1, dw2};
    endfunction

    task automatic start_chunk(input logic [31:0] a, input logic [31:0] s, input logic w);
        cur_addr = a; cur_size = s; cur_dir = w;
        dma_address_host = a; dma_size = s; dma_dir_write = w;
        dma_pending = 1'b1;
        cyc = 0;
    endtask

    task automatic finish_chunk(input int hold, input bit chk_lat);
        bit          illegal, saw, ok;
        int          bound, tag;
        logic [95:0] first_hdr;
        illegal = (cur_size == 0) || (cur_size > 4096) || (cur_size % 4 != 0) || (cur_addr % 4 != 0);
        m_hdr_ready  = (hold == 0);
        wr_req_ready = (hold == 0);
        bound = 0;
        tag = -1;
        if (illegal) begin
            saw = 0;
            do begin
                tick(); bound++;
                if (m_hdr_valid || wr_req_valid) saw = 1;
            end while (!dma_done && bound < 20);
            chk("illegal_done", dma_done, 1);
            chk("illegal_err_size", err_size, 1);
            chk("illegal_no_request", saw, 0);
            if (chk_lat) chk("illegal_latency", cyc, 2);
        end else if (cur_dir) begin
            do begin tick(); bound++; end while (!wr_req_valid && bound < 20);
            chk("wr_valid", wr_req_valid, 1);
            if (chk_lat) chk("wr_latency", cyc, 2);
            ok = 1;
            repeat (hold) begin
                tick();
                if (!(wr_req_valid && !dma_done)) ok = 0;
            end
            if (hold > 0) chk("wr_held", ok, 1);
            wr_req_ready = 1'b1;
            tick();
            chk("wr_done", dma_done, 1);
            chk("wr_valid_drop", wr_req_valid, 0);
            wr_req_ready = 1'b0;
        end else begin
            tag = model_lowest();
            do begin tick(); bound++; end while (!m_hdr_valid && bound < 100);
            chk("hdr_valid", m_hdr_valid, 1);
            if (chk_lat) chk("hdr_latency", cyc, 2);
            chk("hdr", m_hdr, exp_hdr(cur_addr, cur_size, cfg_requester_id, tag));
            if (tag >= 0) used[tag] = 1;
            chk("outstanding_alloc", outstanding, model_count());
            first_hdr = m_hdr;
            ok = 1;
            repeat (hold) begin
                tick();
                if (!(m_hdr_valid && (m_hdr === first_hdr) && !dma_done)) ok = 0;
            end
            if (hold > 0) chk("hdr_held", ok, 1);
            m_hdr_ready = 1'b1;
            tick();
            chk("rd_done", dma_done, 1);
            chk("hdr_valid_drop", m_hdr_valid, 0);
            m_hdr_ready = 1'b0;
        end
        $display("chunk addr=%08h size=%0d write=%0d hold=%0d tag=%0d outstanding=%0d",
                 cur_addr, cur_size, cur_dir, hold, tag, outstanding);
        dma_pending = 1'b0;
        tick();
        chk("done_one_cycle", {dma_done, err_size}, 2'b00);
    endtask

    task automatic do_free(input int t);
        bit exp_sp;
        if (t < NUM_TAGS) exp_sp = !used[t];
        else              exp_sp = 1;
        cpl_free_valid = 1'b1;
        cpl_free_tag   = 8'(t);
        tick();
        cpl_free_valid = 1'b0;
        if (!exp_sp) used[t] = 0;
        chk("spurious", err_spurious, exp_sp);
        chk("outstanding_free", outstanding, model_count());
        $display("free tag=%0d spurious=%0d outstanding=%0d", t, err_spurious, outstanding);
    endtask

    initial begin
        bit ok;
        int r, t, bound;
        logic [31:0] a, s;

        i_rst = 1'b1;
        cfg_requester_id = 16'h0100;
        dma_pending = 1'b0; dma_address_host = '0; dma_size = '0; dma_dir_write = 1'b0;
        m_hdr_ready = 1'b0; wr_req_ready = 1'b0;
        cpl_free_valid = 1'b0; cpl_free_tag = '0;
        for (int i = 0; i < NUM_TAGS; i++) used[i] = 0;
        tick(); tick();
        chk("reset_outputs", {dma_done, m_hdr_valid, wr_req_valid, err_size, err_spurious}, 5'b0);
        chk("reset_hdr", m_hdr, 96'd0);
        chk("reset_outstanding", outstanding, 0);
        i_rst = 1'b0;

        // Basic read: expect DW0 len 32, DW1 0x010000FF, DW2 0x1000.
        start_chunk(32'h1000, 128, 1'b0);
        finish_chunk(0, 1);
        // Single-DW read and 4096-byte read.
        start_chunk(32'h2000, 4, 1'b0);
        finish_chunk(0, 1);
        start_chunk(32'h3000, 4096, 1'b0);
        finish_chunk(0, 1);
        // Back-pressure for 5 cycles.
        start_chunk(32'h4000, 64, 1'b0);
        finish_chunk(5, 1);
        // Illegal chunks.
        start_chunk(32'h5000, 0, 1'b0);  finish_chunk(0, 1);
        start_chunk(32'h5000, 6, 1'b0);  finish_chunk(0, 1);
        start_chunk(32'h0002, 8, 1'b0);  finish_chunk(0, 1);
        start_chunk(32'h5000, 4100, 1'b0); finish_chunk(0, 1);
        // Spurious frees and write chunks.
        do_free(20);
        do_free(40);
        start_chunk(32'h6000, 256, 1'b1); finish_chunk(3, 1);
        start_chunk(32'h7000, 512, 1'b1); finish_chunk(0, 1);

        // Release everything, then exhaust the pool.
        for (int i = 0; i < NUM_TAGS; i++) if (used[i]) do_free(i);
        for (int i = 0; i < NUM_TAGS; i++) begin
            start_chunk(32'h10000 + 32'(i * 64), 64, 1'b0);
            finish_chunk(0, 1);
        end
        chk("pool_full", outstanding, NUM_TAGS);
        start_chunk(32'h20000, 32, 1'b0);
        ok = 1;
        repeat (8) begin
            tick();
            if (m_hdr_valid || dma_done) ok = 0;
        end
        chk("stall_no_hdr", ok, 1);
        do_free(3);
        finish_chunk(0, 0);

        // Randomized chunks and frees.
        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(0, 2);
            repeat (r) begin
                t = $urandom_range(0, 47);
                do_free(t);
            end
            if (model_count() == NUM_TAGS) begin
                do t = $urandom_range(0, NUM_TAGS - 1); while (!used[t]);
                do_free(t);
            end
            cfg_requester_id = 16'($urandom);
            a = $urandom & 32'hFFFF_FFFC;
            s = 4 * $urandom_range(1, 1024);
            r = $urandom_range(0, 9);
            if (r == 0) s = $urandom_range(0, 8200);
            if (r == 1) a = a | 32'($urandom_range(1, 3));
            start_chunk(a, s, ($urandom_range(0, 3) == 0));
            finish_chunk($urandom_range(0, 3), 1);
        end

        // Asynchronous reset while a header is waiting.
        if (model_lowest() < 0) do_free(0);
        start_chunk(32'h8000, 16, 1'b0);
        bound = 0;
        do begin tick(); bound++; end while (!m_hdr_valid && bound < 20);
        chk("pre_reset_valid", m_hdr_valid, 1);
        #2 i_rst = 1'b1;
        #1;
        chk("async_reset_valid", m_hdr_valid, 0);
        chk("async_reset_outstanding", outstanding, 0);
        chk("async_reset_hdr", m_hdr, 96'd0);
        for (int i = 0; i < NUM_TAGS; i++) used[i] = 0;
        dma_pending = 1'b0;
        tick();
        i_rst = 1'b0;
        start_chunk(32'h9000, 16, 1'b0);
        finish_chunk(0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
